// File: rtl/bp_fe_queue_rollback_if.sv
// Handshake bundle between the FE fetch side, the checkpointed queue and the BE.
// The queue owns the slave side; FE/BE logic owns the master side.
//
// Purpose:
//   Groups every fe_queue_* signal so that the queue and its neighbours
//   connect through one port.
//
// Signals (direction seen from the queue):
//   fe_queue_i        in   packet from the FE
//   fe_queue_v_i      in   FE packet valid
//   fe_queue_ready_o  out  space available
//   fe_queue_o        out  entry at the speculative read pointer
//   fe_queue_v_o      out  an unread entry exists
//   fe_queue_yumi_i   in   BE consumes fe_queue_o
//   fe_queue_deq_i    in   BE commits the oldest entry
//   fe_queue_roll_i   in   BE rewinds reads to the oldest uncommitted entry
//   fe_queue_clr_i    in   BE flushes every entry
//   fe_queue_empty_o  out  no resident entries
interface bp_fe_queue_rollback_if
  #(parameter int width_p = 64);

  logic [width_p-1:0] fe_queue_i;
  logic               fe_queue_v_i;
  logic               fe_queue_ready_o;

  logic [width_p-1:0] fe_queue_o;
  logic               fe_queue_v_o;
  logic               fe_queue_yumi_i;

  logic               fe_queue_deq_i;
  logic               fe_queue_roll_i;
  logic               fe_queue_clr_i;
  logic               fe_queue_empty_o;

  // FE and BE side: drives packets and control, observes the queue
  modport master (
    output fe_queue_i,
    output fe_queue_v_i,
    input  fe_queue_ready_o,
    input  fe_queue_o,
    input  fe_queue_v_o,
    output fe_queue_yumi_i,
    output fe_queue_deq_i,
    output fe_queue_roll_i,
    output fe_queue_clr_i,
    input  fe_queue_empty_o
  );

  // Queue side
  modport slave (
    input  fe_queue_i,
    input  fe_queue_v_i,
    output fe_queue_ready_o,
    output fe_queue_o,
    output fe_queue_v_o,
    input  fe_queue_yumi_i,
    input  fe_queue_deq_i,
    input  fe_queue_roll_i,
    input  fe_queue_clr_i,
    output fe_queue_empty_o
  );

endinterface

// File: rtl/bp_fe_queue_rollback.sv
// Checkpointed instruction FIFO between the front end and the back end.
// Entries are read speculatively and stay resident until committed.
//
// Purpose:
//   Three pointers share one storage array. wptr appends FE packets,
//   rptr walks them speculatively for the BE checker, cptr retires
//   them on deq. roll rewinds rptr to cptr, clr drops everything.
//
// Parameters:
//   bp_params_p   processor config (0 = e_bp_inv_cfg), sets packet width
//   els_p         queue depth, power of two, >= 2
//
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   reset_i       synchronous active-high reset
//   fe_if         slave side of bp_fe_queue_rollback_if
//
// Build option:
//   BP_FE_QUEUE_BYPASS_EN  present an enqueue on an otherwise empty
//                          read side in the same cycle.
module bp_fe_queue_rollback
  #(parameter int bp_params_p = 0
  , parameter int els_p = 8
  , localparam int ptr_width_lp = $clog2(els_p) + 1
  , localparam int fe_queue_width_lp = (bp_params_p == 0) ? 64 : 128
  )
  (input  logic                 clk_i
  , input logic                 reset_i
  , bp_fe_queue_rollback_if.slave fe_if
  );

  localparam int idx_width_lp = ptr_width_lp - 1;

  typedef logic [ptr_width_lp-1:0] ptr_t;
  typedef logic [idx_width_lp-1:0] idx_t;
  typedef logic [fe_queue_width_lp-1:0] pkt_t;

  localparam ptr_t els_lp = ptr_t'(els_p);

  if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_els
    $error("els_p must be a power of two and at least 2");
  end

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t cptr_q, cptr_d;
  ptr_t cptr_adv;

  pkt_t mem_q [els_p];

  logic occ_full;
  logic unread;
  logic enq;
  logic wr_en;
  logic byp;

  idx_t widx;
  idx_t ridx;

  // Occupancy wraps with the pointers; MSB separates full from empty
  assign occ_full = ((wptr_q - cptr_q) == els_lp);
  assign unread   = (rptr_q != wptr_q);

  assign widx = wptr_q[idx_width_lp-1:0];
  assign ridx = rptr_q[idx_width_lp-1:0];

  // ready comes from registers only; a deq frees its slot next cycle
  assign enq = fe_if.fe_queue_v_i & ~occ_full;

  // A flush in the same cycle drops the incoming packet
  assign wr_en = enq & ~fe_if.fe_queue_clr_i;

`ifdef BP_FE_QUEUE_BYPASS_EN
  // Read side is caught up with the write side, so the incoming
  // packet is the next entry; it is still written for later replay
  assign byp = enq
             & (rptr_q == wptr_q)
             & ~fe_if.fe_queue_clr_i
             & ~fe_if.fe_queue_roll_i;
`else
  assign byp = 1'b0;
`endif

  // Commit happens before the rewind when roll and deq coincide
  assign cptr_adv = cptr_q + ptr_t'(fe_if.fe_queue_deq_i);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    priority case (1'b1)
      fe_if.fe_queue_clr_i: begin
        rptr_d = wptr_q;
        cptr_d = wptr_q;
      end
      fe_if.fe_queue_roll_i: begin
        cptr_d = cptr_adv;
        rptr_d = cptr_adv;
        wptr_d = wptr_q + ptr_t'(enq);
      end
      default: begin
        rptr_d = rptr_q + ptr_t'(fe_if.fe_queue_yumi_i);
        cptr_d = cptr_adv;
        wptr_d = wptr_q + ptr_t'(enq);
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // Storage holds no reset value; pointers alone decide validity
  always_ff @(posedge clk_i) begin
    if (wr_en & ~reset_i) begin
      mem_q[widx] <= fe_if.fe_queue_i;
    end
  end

  assign fe_if.fe_queue_ready_o = ~occ_full;
  assign fe_if.fe_queue_empty_o = (wptr_q == cptr_q);
  assign fe_if.fe_queue_v_o     = unread | byp;

`ifdef BP_FE_QUEUE_BYPASS_EN
  always_comb begin
    fe_if.fe_queue_o = '0;
    if (unread) begin
      fe_if.fe_queue_o = mem_q[ridx];
    end else if (byp) begin
      fe_if.fe_queue_o = fe_if.fe_queue_i;
    end
  end
`else
  assign fe_if.fe_queue_o = unread ? mem_q[ridx] : '0;
`endif

  // Protocol checks on the BE and FE sides
  a_yumi_needs_v: assert property (
    @(posedge clk_i) disable iff (reset_i)
    fe_if.fe_queue_yumi_i |-> fe_if.fe_queue_v_o
  ) else $error("yumi asserted with no entry presented");

  a_deq_needs_read: assert property (
    @(posedge clk_i) disable iff (reset_i)
    fe_if.fe_queue_deq_i |-> (cptr_q != rptr_q)
  ) else $error("deq asserted with no read-but-uncommitted entry");

  a_hold_stable: assert property (
    @(posedge clk_i) disable iff (reset_i)
    (fe_if.fe_queue_v_i & occ_full)
      |=> (~fe_if.fe_queue_v_i | $stable(fe_if.fe_queue_i))
  ) else $error("FE packet changed while stalled");

endmodule

// File: tb/tb_bp_fe_queue_rollback.sv
// Directed bench for bp_fe_queue_rollback with an integer-pointer model.
// Outputs are compared every cycle plus literal spot checks.
module tb_bp_fe_queue_rollback;

  logic clk;
  logic rst;

  bp_fe_queue_rollback_if #(.width_p(64)) fe_if();

  bp_fe_queue_rollback #(.bp_params_p(0), .els_p(8)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .fe_if  (fe_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;

  // Model: unbounded sequence numbers, data by absolute position
  int mw, mr, mc;
  logic [63:0] mm [int];
  bit armed;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (mw - mc) < 8;
  endfunction

  function automatic bit m_byp();
`ifdef BP_FE_QUEUE_BYPASS_EN
    return (mr == mw) && fe_if.fe_queue_v_i && m_ready()
        && !fe_if.fe_queue_clr_i && !fe_if.fe_queue_roll_i;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    armed = 0;
    mw = 0; mr = 0; mc = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mw = 0; mr = 0; mc = 0;
        armed = 1;
      end else begin
        bit en;
        en = fe_if.fe_queue_v_i && m_ready();
        if (fe_if.fe_queue_clr_i) begin
          mr = mw;
          mc = mw;
        end else if (fe_if.fe_queue_roll_i) begin
          if (fe_if.fe_queue_deq_i) mc = mc + 1;
          mr = mc;
          if (en) begin
            mm[mw] = fe_if.fe_queue_i;
            mw = mw + 1;
          end
        end else begin
          if (en) begin
            mm[mw] = fe_if.fe_queue_i;
            mw = mw + 1;
          end
          if (fe_if.fe_queue_yumi_i) mr = mr + 1;
          if (fe_if.fe_queue_deq_i) mc = mc + 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        logic [63:0] eo;
        bit ev;
        ev = (mr < mw) || m_byp();
        if (mr < mw) eo = mm[mr];
        else if (m_byp()) eo = fe_if.fe_queue_i;
        else eo = '0;
        chk("ready", 64'(fe_if.fe_queue_ready_o), 64'(m_ready()));
        chk("v_o", 64'(fe_if.fe_queue_v_o), 64'(ev));
        chk("o", fe_if.fe_queue_o, eo);
        chk("empty", 64'(fe_if.fe_queue_empty_o), 64'(mw == mc));
      end
    end
  end

  task automatic idle();
    fe_if.fe_queue_i = '0;
    fe_if.fe_queue_v_i = 0;
    fe_if.fe_queue_yumi_i = 0;
    fe_if.fe_queue_deq_i = 0;
    fe_if.fe_queue_roll_i = 0;
    fe_if.fe_queue_clr_i = 0;
  endtask

  task automatic cyc(bit v, logic [63:0] d, bit y, bit dq, bit rl, bit cl);
    fe_if.fe_queue_v_i = v;
    fe_if.fe_queue_i = d;
    fe_if.fe_queue_yumi_i = y;
    fe_if.fe_queue_deq_i = dq;
    fe_if.fe_queue_roll_i = rl;
    fe_if.fe_queue_clr_i = cl;
    @(posedge clk);
    #1;
    idle();
  endtask

  int nrdy;

  initial begin
    errs = 0;
    checks = 0;
    nrdy = 0;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_ready", 64'(fe_if.fe_queue_ready_o), 64'd1);
    chk("rst_v", 64'(fe_if.fe_queue_v_o), 64'd0);
    chk("rst_empty", 64'(fe_if.fe_queue_empty_o), 64'd1);
    chk("rst_o", fe_if.fe_queue_o, 64'd0);
    repeat (10) cyc(0, 0, 0, 0, 0, 0);

    // Fill and drain
    for (int i = 1; i <= 8; i++) cyc(1, 64'(i), 0, 0, 0, 0);
    chk("full_ready", 64'(fe_if.fe_queue_ready_o), 64'd0);
    chk("full_o", fe_if.fe_queue_o, 64'h1);
    repeat (8) cyc(0, 0, 1, 0, 0, 0);
    chk("drain_v", 64'(fe_if.fe_queue_v_o), 64'd0);
    chk("drain_empty", 64'(fe_if.fe_queue_empty_o), 64'd0);
    chk("drain_ready", 64'(fe_if.fe_queue_ready_o), 64'd0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("deq_ready", 64'(fe_if.fe_queue_ready_o), 64'd1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("clr_empty", 64'(fe_if.fe_queue_empty_o), 64'd1);

    // Rollback
    cyc(1, 64'hA, 0, 0, 0, 0);
    cyc(1, 64'hB, 1, 0, 0, 0);
    cyc(1, 64'hC, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("roll_o", fe_if.fe_queue_o, 64'hB);
    chk("roll_v", 64'(fe_if.fe_queue_v_o), 64'd1);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("rolldeq_o", fe_if.fe_queue_o, 64'hC);
    cyc(0, 0, 0, 0, 0, 1);

    // Flush with a same-cycle enqueue
    cyc(1, 64'h11, 0, 0, 0, 0);
    cyc(1, 64'hD, 0, 0, 0, 1);
    chk("clr_v", 64'(fe_if.fe_queue_v_o), 64'd0);
    chk("clr_empty2", 64'(fe_if.fe_queue_empty_o), 64'd1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);

    // Reset mid-operation with an enqueue pending
    cyc(1, 64'h21, 0, 0, 0, 0);
    cyc(1, 64'h22, 1, 0, 0, 0);
    rst = 1;
    cyc(1, 64'h23, 0, 0, 0, 0);
    rst = 0;
    chk("mrst_v", 64'(fe_if.fe_queue_v_o), 64'd0);
    chk("mrst_empty", 64'(fe_if.fe_queue_empty_o), 64'd1);
    chk("mrst_ready", 64'(fe_if.fe_queue_ready_o), 64'd1);

    // Streaming across several pointer wraps
    for (int k = 0; k < 102; k++) begin
      fe_if.fe_queue_v_i = (k < 100);
      fe_if.fe_queue_i = 64'h100 + 64'(k);
      fe_if.fe_queue_yumi_i = (k >= 1 && k <= 100);
      fe_if.fe_queue_deq_i = (k >= 2);
      #1;
      if (!fe_if.fe_queue_ready_o) nrdy++;
      if (k >= 1 && k <= 100)
        chk("stream_o", fe_if.fe_queue_o, 64'h100 + 64'(k - 1));
      @(posedge clk);
      #1;
    end
    idle();
    chk("stream_ready_drops", 64'(nrdy), 64'd0);
    chk("stream_empty", 64'(fe_if.fe_queue_empty_o), 64'd1);

`ifdef BP_FE_QUEUE_BYPASS_EN
    fe_if.fe_queue_v_i = 1;
    fe_if.fe_queue_i = 64'hE;
    fe_if.fe_queue_yumi_i = 1;
    #1;
    chk("byp_o", fe_if.fe_queue_o, 64'hE);
    chk("byp_v", 64'(fe_if.fe_queue_v_o), 64'd1);
    @(posedge clk);
    #1;
    idle();
    cyc(0, 0, 0, 0, 1, 0);
    chk("byp_roll_o", fe_if.fe_queue_o, 64'hE);
    chk("byp_roll_v", 64'(fe_if.fe_queue_v_o), 64'd1);
`endif

    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/bp_fe_queue_rollback.md
# bp_fe_queue_rollback

Checkpointed instruction FIFO between the front end and the back end. Fetch packets from the FE are enqueued on one side. The BE checker reads them speculatively on the other side. Entries stay resident until the BE commits them (`deq`). The BE can rewind to the oldest uncommitted entry (`roll`) or discard everything (`clr`). This block drives the `fe_queue_*` port group of `bp_be_top` and consumes its `fe_queue_yumi_o`, `fe_queue_deq_o`, `fe_queue_roll_o` and `fe_queue_clr_o`.

## Interface
- `bp_params_p`, default `e_bp_inv_cfg`: processor config. `fe_queue_width_lp` is derived from it.
- `els_p`, default 8: queue depth. Must be a power of two, ≥2.
- `ptr_width_lp`, `$clog2(els_p)+1`: pointer width; the MSB is the wrap bit.

Ports:
- `clk_i`, in, 1: clock. One clock; all state updates on its rising edge.
- `reset_i`, in, 1: synchronous, active-high reset.
- `fe_queue_i`, in, `fe_queue_width_lp`: packet from the FE.
- `fe_queue_v_i`, in, 1: FE packet valid.
- `fe_queue_ready_o`, out, 1: space available; enqueue occurs when v_i & ready_o.
- `fe_queue_o`, out, `fe_queue_width_lp`: entry at the read pointer; driven '0 when v_o=0.
- `fe_queue_v_o`, out, 1: an unread entry exists.
- `fe_queue_yumi_i`, in, 1: BE consumes `fe_queue_o`; advances the read pointer.
- `fe_queue_deq_i`, in, 1: commit the oldest entry; advances the checkpoint pointer.
- `fe_queue_roll_i`, in, 1: rewind the read pointer to the checkpoint.
- `fe_queue_clr_i`, in, 1: flush all entries.
- `fe_queue_empty_o`, out, 1: no resident entries (wptr==cptr). Used for fence/drain.

## Operation
- State:
  - `wptr`: write pointer.
  - `rptr`: speculative read pointer.
  - `cptr`: commit pointer.
  - `els_p`×`fe_queue_width_lp` storage.
  - Invariant: cptr ≤ rptr ≤ wptr, in modular order.
- Occupancy is `wptr−cptr`, computed mod 2^ptr_width. Full when occupancy==els_p. Unread exists when rptr≠wptr.
- `fe_queue_ready_o = ~full`. It is computed from registers only, with no combinational path from any input.
- Enqueue writes `mem[wptr[lsbs]]` and increments wptr.
- Next-state priority, per cycle:
  1. clr: rptr←cptr←wptr. A same-cycle enqueue is discarded and wptr does not advance. yumi, deq and roll are ignored.
  2. roll: cptr advances first if deq is asserted, then rptr←cptr_next. A same-cycle yumi is ignored. A same-cycle enqueue proceeds.
  3. Otherwise: rptr increments on yumi, cptr increments on deq, wptr increments on enqueue. All three are independent and may fire in the same cycle.
- A slot freed by deq becomes writable the next cycle. Deq does not bypass into ready.
- Illegal inputs, flagged with a simulation assertion and undefined in hardware:
  - yumi while v_o=0.
  - deq when cptr==rptr.
  - v_i held without ready, with data changing.
- Pointer wrap: the low bits index storage and the MSB disambiguates full from empty. Increments wrap naturally at 2^ptr_width.

## Timing
- Reset values: all pointers 0; `fe_queue_ready_o`=1, `fe_queue_v_o`=0, `fe_queue_o`='0, `fe_queue_empty_o`=1. Storage contents are not reset.
- Reset asserted mid-operation behaves exactly like the reset values above; all other inputs are ignored that cycle.
- Enqueue at cycle N: the entry is visible on v_o/o at N+1 (default build).
- Yumi at N: the next entry is presented at N+1.
- Roll at N: the oldest uncommitted entry is presented at N+1.
- Clr at N: v_o=0 and empty_o=1 at N+1.
- Fill/drain: ready_o drops the cycle after the els_p-th outstanding enqueue. It rises the cycle after the deq that frees a slot.

## Configuration
- `BP_FE_QUEUE_BYPASS_EN` defined:
  - When rptr==wptr and v_i & ready_o, `fe_queue_o`=`fe_queue_i` and v_o=1 in the same cycle.
  - The entry is still written to storage. A same-cycle yumi advances rptr with wptr, so a later roll can replay it.
  - Bypass is suppressed in any cycle with clr_i or roll_i asserted.
- Undefined: no bypass; minimum enqueue-to-present latency is 1 cycle. `fe_queue_o` and v_o depend on registers only.

## Test plan
- Reset then idle: ready_o=1, v_o=0, empty_o=1, o='0 for 10 cycles.
- Fill/drain, els_p=8:
  - Enqueue 8 packets 0x1..0x8 with no yumi: ready_o=0 after the 8th.
  - Yumi 8 times: v_o=0, empty_o=0, ready_o still 0.
  - Deq once: ready_o=1 next cycle.
- Rollback:
  - Enqueue A, B, C; yumi A, B; deq once; roll.
  - Next cycle o=B, v_o=1.
  - Yumi B, C, then roll+deq in the same cycle: o=C next.
- Clr with a simultaneous enqueue of D: next cycle v_o=0, empty_o=1, and D is never presented.
- Wrap-around: stream 100 sequential packets with yumi+deq every cycle. Output order is exact and ready_o never deasserts.
- Bypass, macro defined: empty queue, enqueue E with yumi in the same cycle → o=E, v_o=1 that cycle. Then roll (no deq) → o=E again next cycle.
